// File: rtl/lift_request_scheduler.sv
// rtl/lift_request_scheduler.sv - SCAN call scheduler with floor tracking and door dwell sequencing
module lift_request_scheduler #(
    parameter int NUM_FLOORS = 11,
    parameter int FLOOR_W    = 4,
    parameter int DOOR_DWELL = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req_in,
    input  logic                  floor_tick,
    input  logic                  in_door_obstacle,
    input  logic                  in_door_open,
    input  logic                  in_door_close,
    output logic                  out_up_direction,
    output logic                  out_down_direction,
    output logic                  out_door_open,
    output logic                  out_ready,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int DW = $clog2(DOOR_DWELL + 1);
    localparam logic [DW-1:0]      DWELL_LOAD = DW'(DOOR_DWELL - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVING, DOORS} state_t;

    state_t                  state, state_nx;
    logic                    dir_up, dir_nx;
    logic [FLOOR_W-1:0]      floor_nx;
    logic [DW-1:0]           dwell, dwell_nx;
    logic [NUM_FLOORS-1:0]   live, pend_nx;
    logic                    req_above, req_below;
    logic                    at_end;

    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i > int'(cur_floor))) req_above = 1'b1;
            if (pending[i] && (i < int'(cur_floor))) req_below = 1'b1;
        end
    end

    // A tick at the end of travel is dropped so the floor index saturates.
    assign at_end = dir_up ? (cur_floor == TOP_FLOOR) : (cur_floor == '0);

    always_comb begin
        state_nx = state;
        dir_nx   = dir_up;
        floor_nx = cur_floor;
        dwell_nx = dwell;
        live     = pending | req_in;
        case (state)
            IDLE: begin
                if (pending[cur_floor]) begin
                    state_nx = DOORS;
                    dwell_nx = DWELL_LOAD;
                end else if (req_above && (dir_up || !req_below)) begin
                    state_nx = MOVING;
                    dir_nx   = 1'b1;
                end else if (req_below) begin
                    state_nx = MOVING;
                    dir_nx   = 1'b0;
                end
            end
            MOVING: begin
                if (floor_tick && !at_end) begin
                    floor_nx = dir_up ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
                    if (live[floor_nx]) begin
                        state_nx = DOORS;
                        dwell_nx = DWELL_LOAD;
                    end
                end
            end
            DOORS: begin
                if (in_door_obstacle || in_door_open || req_in[cur_floor]) begin
                    dwell_nx = DWELL_LOAD;
                end else if (in_door_close || (dwell == '0)) begin
                    state_nx = IDLE;
                end else begin
                    dwell_nx = dwell - DW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        // The floor whose door is open (or opening) absorbs its own request.
        pend_nx = live & ~((state_nx == DOORS) ? (NUM_FLOORS'(1) << floor_nx) : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            dir_up             <= 1'b1;
            cur_floor          <= '0;
            dwell              <= '0;
            pending            <= '0;
            out_up_direction   <= 1'b0;
            out_down_direction <= 1'b0;
            out_door_open      <= 1'b0;
            out_ready          <= 1'b1;
        end else begin
            state              <= state_nx;
            dir_up             <= dir_nx;
            cur_floor          <= floor_nx;
            dwell              <= dwell_nx;
            pending            <= pend_nx;
            out_up_direction   <= (state_nx == MOVING) && dir_nx;
            out_down_direction <= (state_nx == MOVING) && !dir_nx;
            out_door_open      <= (state_nx == DOORS);
            out_ready          <= (state_nx == IDLE) && (pend_nx == '0);
        end
    end

endmodule
